// File: rtl/dmux_pkg.sv
// Shared types and constants for the fast-to-slow req/ack data distributor.
package dmux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CLR  = 2'd2
    } state_t;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int DROP_CNT_W      = 16;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
        end
    end

    assign q = sync[STAGES-1];

endmodule

// File: rtl/dmux_fast2slow.sv
// Fast (clk_a) to slow (clk_b) multi-bit CDC using a four-phase req/ack handshake.
// Optional dropped-offer counter enabled with `define DMUX_DROP_CNT_EN.
module dmux_fast2slow
    import dmux_pkg::*;
#(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk_a,
    input  logic          rst_n,
    input  logic          clk_b,
    input  logic [DW-1:0] data_in,
    input  logic          data_in_valid,
    output logic          data_in_ready,
    output logic [DW-1:0] data_out,
    output logic          data_out_valid
`ifdef DMUX_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    state_t        state;
    state_t        state_nxt;
    logic          req;
    logic          req_nxt;
    logic          accept;
    logic [DW-1:0] hold_reg;
    logic          ack;
    logic          ack_sync_a;
    logic          req_sync_b;
    logic          req_sync_d;

    // Source FSM, clk_a domain
    always_comb begin
        state_nxt = state;
        req_nxt   = req;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (data_in_valid) begin
                    accept    = 1'b1;
                    req_nxt   = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (ack_sync_a) begin
                    req_nxt   = 1'b0;
                    state_nxt = CLR;
                end
            end
            CLR: begin
                if (!ack_sync_a) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                req_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req      <= 1'b0;
            hold_reg <= '0;
        end else begin
            state <= state_nxt;
            req   <= req_nxt;
            if (accept) begin
                hold_reg <= data_in;
            end
        end
    end

    // Ready comes from the state register alone so the source sees no comb loop through valid.
    assign data_in_ready = (state == IDLE);

    cdc_sync_bit #(.STAGES(SYNC_N)) u_req_sync (
        .clk   (clk_b),
        .rst_n (rst_n),
        .d     (req),
        .q     (req_sync_b)
    );

    cdc_sync_bit #(.STAGES(SYNC_N)) u_ack_sync (
        .clk   (clk_a),
        .rst_n (rst_n),
        .d     (ack),
        .q     (ack_sync_a)
    );

    // Destination, clk_b domain: hold_reg is stable while req is high, so sampling it is safe
    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            req_sync_d     <= 1'b0;
            ack            <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            req_sync_d     <= req_sync_b;
            ack            <= req_sync_b;
            data_out_valid <= req_sync_b && !req_sync_d;
            if (req_sync_b && !req_sync_d) begin
                data_out <= hold_reg;
            end
        end
    end

`ifdef DMUX_DROP_CNT_EN
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (data_in_valid && !data_in_ready) begin
            drop_cnt <= sat_inc(drop_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_dmux_fast2slow.sv
// Randomized scoreboard bench for dmux_fast2slow across several clock ratios.
`timescale 1ns/1ps
module tb_dmux_fast2slow;

    logic       clk_a;
    logic       clk_b;
    logic       rst_n;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;
    logic [7:0] data_out;
    logic       data_out_valid;
`ifdef DMUX_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int ha = 5;
    int hb = 20;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         exp_drop = 0;
    bit         prev_acc = 0;

    dmux_fast2slow #(.DW(8), .SYNC_STAGES(2)) dut (
        .clk_a          (clk_a),
        .rst_n          (rst_n),
        .clk_b          (clk_b),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid)
`ifdef DMUX_DROP_CNT_EN
        ,
        .drop_cnt       (drop_cnt)
`endif
    );

    initial begin
        clk_a = 1'b0;
        forever #(ha) clk_a = ~clk_a;
    end

    initial begin
        clk_b = 1'b0;
        #3;
        forever #(hb) clk_b = ~clk_b;
    end

    // Every observed output pulse is recorded; duplicates or long pulses show up as extra entries
    always @(posedge clk_b) begin
        #1;
        if (data_out_valid === 1'b1) got_q.push_back(data_out);
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input logic [7:0] d, input bit only_rdy, output bit acc);
        logic rd;
        @(negedge clk_a);
        rd = data_in_ready;
        if (prev_acc) begin
            n_checks++;
            if (rd !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_after_accept: got %b expected 0", rd);
            end
        end
        data_in_valid = v && (!only_rdy || (rd === 1'b1));
        data_in       = d;
        acc = data_in_valid && (rd === 1'b1);
        if (acc) exp_q.push_back(d);
        else if (data_in_valid && exp_drop != 16'hFFFF) exp_drop++;
        prev_acc = acc;
    endtask

    task automatic wait_drain(output bit to);
        to = 1'b1;
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk_a);
            if (got_q.size() >= exp_q.size() && data_in_ready === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
        repeat (8) @(posedge clk_b);
        #1;
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        data_in_valid = 1'b0;
        data_in       = 8'h00;
        repeat (2) @(posedge clk_b);
        #1;
        n_checks++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout_during: got %h expected 00", data_out); end
        n_checks++;
        if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dvalid_during: got %b expected 0", data_out_valid); end
        n_checks++;
        if (data_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_during: got %b expected 1", data_in_ready); end
        repeat (3) @(posedge clk_b);
        @(negedge clk_a);
        rst_n = 1'b1;
        repeat (4) @(posedge clk_b);
        #1;
        n_checks++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout_after: got %h expected 00", data_out); end
        n_checks++;
        if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dvalid_after: got %b expected 0", data_out_valid); end
        n_checks++;
        if (data_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b expected 1", data_in_ready); end
`ifdef DMUX_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
`endif
        got_q.delete();
        exp_q.delete();
        exp_drop = 0;
    endtask

    task automatic test_single_word;
        bit acc;
        bit to;
        int edges;
        bit back;
        drive(1'b1, 8'hA5, 1'b0, acc);
        n_checks++;
        if (acc !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %b expected 1", acc); end
        @(posedge clk_a);
        #1;
        data_in_valid = 1'b0;
        prev_acc = 1'b0;
        edges = 0;
        while (edges < 8) begin
            @(posedge clk_b);
            #1;
            edges++;
            if (data_out_valid === 1'b1) break;
        end
        n_checks++;
        if (edges < 3 || edges > 4) begin n_fail++; $display("FAIL single_latency: got %0d clk_b edges expected 3..4", edges); end
        n_checks++;
        if (data_out !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", data_out); end
        n_checks++;
        if (data_in_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_busy: got %b expected 0", data_in_ready); end
        back = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk_a);
            if (data_in_ready === 1'b1) begin back = 1'b1; break; end
        end
        n_checks++;
        if (back !== 1'b1) begin n_fail++; $display("FAIL single_ready_return: got %b expected 1", back); end
        wait_drain(to);
        n_checks++;
        if (got_q.size() != 1) begin n_fail++; $display("FAIL single_pulse_count: got %0d expected 1", got_q.size()); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_stream;
        bit acc;
        bit to;
        int idx;
        int guard;
        idx = 1;
        guard = 0;
        while (idx <= 16 && guard < 3000) begin
            drive(1'b1, 8'(idx), 1'b1, acc);
            if (acc) idx++;
            guard++;
        end
        drive(1'b0, 8'h00, 1'b0, acc);
        n_checks++;
        if (idx != 17) begin n_fail++; $display("FAIL stream_accepted: got %0d expected 16", idx - 1); end
        wait_drain(to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL stream_drain: got timeout expected drain"); end
        n_checks++;
        if (got_q.size() != 16) begin n_fail++; $display("FAIL stream_count: got %0d expected 16", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 16; i++) begin
            n_checks++;
            if (got_q[i] !== 8'(i + 1)) begin n_fail++; $display("FAIL stream_word%0d: got %h expected %h", i, got_q[i], 8'(i + 1)); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_busy_drop;
        bit acc;
        bit to;
        drive(1'b1, 8'h33, 1'b0, acc);
        repeat (3) drive(1'b1, 8'h44, 1'b0, acc);
        drive(1'b0, 8'h00, 1'b0, acc);
        wait_drain(to);
        n_checks++;
        if (got_q.size() != 1) begin n_fail++; $display("FAIL busy_count: got %0d expected 1", got_q.size()); end
        if (got_q.size() > 0) begin
            n_checks++;
            if (got_q[0] !== 8'h33) begin n_fail++; $display("FAIL busy_word: got %h expected 33", got_q[0]); end
        end
`ifdef DMUX_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 16'(exp_drop)) begin n_fail++; $display("FAIL busy_drop_cnt: got %0d expected %0d", drop_cnt, exp_drop); end
`endif
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid;
        bit acc;
        bit to;
        drive(1'b1, 8'h77, 1'b0, acc);
        @(negedge clk_a);
        rst_n         = 1'b0;
        data_in_valid = 1'b0;
        prev_acc      = 1'b0;
        exp_drop      = 0;
        exp_q.delete();
        repeat (5) @(posedge clk_b);
        @(negedge clk_a);
        rst_n = 1'b1;
        repeat (20) @(posedge clk_b);
        #1;
        n_checks++;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL midrst_pulses: got %0d expected 0", got_q.size()); end
        n_checks++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL midrst_dout: got %h expected 00", data_out); end
        got_q.delete();
        drive(1'b1, 8'h5A, 1'b0, acc);
        drive(1'b0, 8'h00, 1'b0, acc);
        wait_drain(to);
        n_checks++;
        if (got_q.size() != 1) begin n_fail++; $display("FAIL midrst_post_count: got %0d expected 1", got_q.size()); end
        if (got_q.size() > 0) begin
            n_checks++;
            if (got_q[0] !== 8'h5A) begin n_fail++; $display("FAIL midrst_post_word: got %h expected 5a", got_q[0]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_ratio_sweep;
        bit acc;
        bit to;
        int has[3] = '{5, 5, 6};
        int hbs[3] = '{35, 10, 2};
        for (int r = 0; r < 3; r++) begin
            ha = has[r];
            hb = hbs[r];
            repeat (5) @(negedge clk_a);
            prev_acc = 1'b0;
            for (int c = 0; c < 400; c++) begin
                drive($urandom_range(0, 3) != 0, 8'($urandom), 1'b0, acc);
            end
            drive(1'b0, 8'h00, 1'b0, acc);
            wait_drain(to);
            n_checks++;
            if (to) begin n_fail++; $display("FAIL sweep%0d_drain: got timeout expected drain", r); end
            n_checks++;
            if (got_q.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL sweep%0d_count: got %0d expected %0d", r, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL sweep%0d_word%0d: got %h expected %h", r, i, got_q[i], exp_q[i]); end
            end
`ifdef DMUX_DROP_CNT_EN
            n_checks++;
            if (drop_cnt !== 16'(exp_drop)) begin n_fail++; $display("FAIL sweep%0d_drop_cnt: got %0d expected %0d", r, drop_cnt, exp_drop); end
`endif
            got_q.delete();
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_stream();
        test_busy_drop();
        test_reset_mid();
        test_ratio_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmux_fast2slow.md
Name: dmux_fast2slow

Overview:
- Multi-bit CDC transmitter path from fast domain clk_a to slow domain clk_b.
- Complements the existing slow-to-fast valid-flag data distributor, where the receiving clock is fast enough to always sample valid.
- In this direction a single-cycle valid can be missed, so the block uses a four-phase req/ack handshake with a stable hold register.
- The source sees back-pressure via data_in_ready; the destination sees exactly one data_out_valid pulse per accepted word.

Parameters:
- DW, 8, data width in bits.
- SYNC_STAGES, 2, synchronizer flops per crossing (minimum 2).

Ports:
- clk_a  input  1  source (fast) clock.
- rst_n  input  1  shared reset for both domains.
- clk_b  input  1  destination (slow) clock.
- data_in  input  DW  source data, clk_a domain.
- data_in_valid  input  1  source offers data_in this clk_a cycle.
- data_in_ready  output  1  source FSM is IDLE; a word is accepted when valid && ready.
- data_out  output  DW  transferred data, clk_b domain; holds last value.
- data_out_valid  output  1  single clk_b-cycle pulse per transferred word.
- drop_cnt  output  16  dropped-offer counter; present only with DMUX_DROP_CNT_EN.
- Interface decision: reset rst_n, asynchronous, active-low; clock clk_a. clk_b registers use the same rst_n.

Behaviour:
- Reset values, all async on rst_n low:
  - FSM=IDLE, hold_reg=0, req=0, ack=0, all sync flops=0.
  - data_out=0, data_out_valid=0, drop_cnt=0.
  - data_in_ready=1 while in reset and after reset release.
- Source FSM (clk_a), states IDLE, REQ, CLR:
  - IDLE: data_in_ready=1. On valid, hold_reg<=data_in, req<=1, go REQ.
  - REQ: ready=0. When ack_sync_a==1: req<=0, go CLR.
  - CLR: ready=0. When ack_sync_a==0: go IDLE.
- data_in_ready is decoded from the state register only; no combinational path from data_in_valid.
- hold_reg is written only in IDLE on accept. It is guaranteed stable while req or ack is high, and is the only multi-bit signal crossing domains.
- Destination (clk_b):
  - req passes through SYNC_STAGES flops to give req_sync_b; req_sync_d is a 1-cycle delayed copy.
  - Rising edge (req_sync_b && !req_sync_d): data_out<=hold_reg and data_out_valid<=1 for exactly one clk_b cycle.
  - ack<=req_sync_b every clk_b cycle (level follows req).
  - ack passes through SYNC_STAGES clk_a flops to give ack_sync_a.
- Latency, from the accept edge to data_out_valid high: SYNC_STAGES+1 clk_b edges, plus up to 1 clk_b cycle of phase uncertainty.
- Throughput: one word per full four-phase round trip, approx 2*(SYNC_STAGES+1) clk_b + 2*(SYNC_STAGES+1) clk_a cycles.
- Boundary conditions:
  - valid while ready=0: the offer is ignored; hold_reg and req are unchanged (drop).
  - valid in the first IDLE cycle after CLR: accepted normally.
  - data_in_valid held high across several ready cycles: one word is accepted per IDLE visit.
  - Reset mid-transfer: both domains clear. A partially crossed word is discarded with no data_out_valid pulse, and no spurious pulse occurs after release.
  - Correct for any clock ratio, including clk_b faster than clk_a.

Optional Feature:
- Macro: DMUX_DROP_CNT_EN.
- Defined:
  - 16-bit clk_a counter increments on each cycle with data_in_valid && !data_in_ready.
  - The counter saturates at 0xFFFF and is cleared by rst_n.
  - drop_cnt port exists.
- Undefined: no counter and no drop_cnt port; drops are silent.

Decomposition:
- Package dmux_pkg:
  - state enum typedef (IDLE, REQ, CLR).
  - SYNC_STAGES_MIN=2 constant.
  - DROP_CNT_W=16 constant.
- One natural sub-module: cdc_sync_bit, a single-bit synchronizer with parameter STAGES and async active-low reset, instantiated twice (req into clk_b, ack into clk_a).

Test Plan:
- Reset: clk_a 100 MHz, clk_b 25 MHz, rst_n low for 5 clk_b cycles. Required: data_out=0x00, data_out_valid=0, data_in_ready=1 during and after reset.
- Single word: 0xA5 with valid for 1 clk_a cycle. Required:
  - data_out=0xA5 with exactly one data_out_valid pulse within 4 clk_b edges.
  - ready=0 until ack_sync_a returns low, then 1.
- Stream: 0x01..0x10, each presented only when ready=1. Required: 16 pulses, values 0x01..0x10 in order, no duplicates or gaps.
- Busy drop: accept 0x33, then present 0x44 for 3 cycles while ready=0. Required: only 0x33 output; with DMUX_DROP_CNT_EN, drop_cnt=3.
- Reset mid-transfer: assert rst_n while in REQ. Required:
  - no data_out_valid pulse, data_out=0.
  - after release, 0x5A transfers correctly.
- Clock ratio sweep: clk_b at 1/7, 1/2 and 3x of clk_a with random data and valid. Required: scoreboard matches every accepted word exactly once, in order.
